// File: rtl/mem_bus_master_pkg.sv
// mem_bus_master_pkg: state encodings and default widths shared by the bus master and its memory
package mem_bus_master_pkg;
  localparam int AWIDTH_DEF = 5;
  localparam int DWIDTH_DEF = 8;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_ISSUE = 3'd2,
    RD_DATA  = 3'd3,
    TURN     = 3'd4
  } state_t;
endpackage

// File: rtl/mem_bus_drv.sv
// mem_bus_drv: tri-state driver isolating the shared mem_data bus
//   oe   - drive enable (registered by the caller)
//   dout - value driven onto bus while oe is high
//   bus  - bidirectional memory data bus
//   din  - current bus value returned to the caller
module mem_bus_drv #(
  parameter int DWIDTH = 8
) (
  input  logic              oe,
  input  logic [DWIDTH-1:0] dout,
  inout  wire  [DWIDTH-1:0] bus,
  output logic [DWIDTH-1:0] din
);
  assign bus = oe ? dout : 'z;
  assign din = bus;
endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: valid/ready request stream to single-port shared-bus memory initiator
//   clk, rst                     - clock, synchronous active-high reset
//   req_valid/req_ready          - request handshake; accepted when both high at a rising edge
//   req_we, req_addr, req_wdata  - request type, address, write data (sampled only at accept)
//   rsp_valid, rsp_we, rsp_rdata - one-cycle completion pulse, op type, read data (held until next read)
//   mem_wr, mem_rd, mem_addr     - memory strobes and address
//   mem_data                     - shared bidirectional data bus, driven only in WRITE
// Define BUS_TURNAROUND_EN to insert one dead TURN cycle after every write.
// A reset sampled at the edge ending WRITE still lets the memory complete that write,
// since the memory samples mem_wr at that same edge and has no reset of its own.
module mem_bus_master
  import mem_bus_master_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_we,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [AWIDTH-1:0] mem_addr,
  inout  wire  [DWIDTH-1:0] mem_data
);
`ifdef BUS_TURNAROUND_EN
  localparam state_t WR_NEXT = TURN;
`else
  localparam state_t WR_NEXT = IDLE;
`endif
  state_t state, state_n;
  logic oe, oe_n, wr_n, rd_n, rv_n, rwe_n;
  logic [AWIDTH-1:0] addr_n;
  logic [DWIDTH-1:0] dout, dout_n, rdata_n, din;
  mem_bus_drv #(.DWIDTH(DWIDTH)) drv (.oe(oe), .dout(dout), .bus(mem_data), .din(din));
  always_comb begin
    state_n = state;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    oe_n    = 1'b0;
    rv_n    = 1'b0;
    addr_n  = mem_addr;
    dout_n  = dout;
    rwe_n   = rsp_we;
    rdata_n = rsp_rdata;
    case (state)
      IDLE: if (req_valid) begin
        state_n = req_we ? WRITE : RD_ISSUE;
        wr_n    = req_we;
        rd_n    = !req_we;
        oe_n    = req_we;
        addr_n  = req_addr;
        dout_n  = req_wdata;
      end
      WRITE: begin
        state_n = WR_NEXT;
        rv_n    = 1'b1;
        rwe_n   = 1'b1;
      end
      RD_ISSUE: begin
        state_n = RD_DATA;
        rd_n    = 1'b1;
      end
      RD_DATA: begin
        state_n = IDLE;
        rv_n    = 1'b1;
        rwe_n   = 1'b0;
        rdata_n = din;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      mem_wr    <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      oe        <= 1'b0;
      dout      <= '0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_n;
      req_ready <= state_n == IDLE;
      mem_wr    <= wr_n;
      mem_rd    <= rd_n;
      mem_addr  <= addr_n;
      oe        <= oe_n;
      dout      <= dout_n;
      rsp_valid <= rv_n;
      rsp_we    <= rwe_n;
      rsp_rdata <= rdata_n;
    end
  end
endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: randomized transaction-level check of mem_bus_master against a shared-bus memory
module tb_mem_bus_master;
  localparam int AW = 5;
  localparam int DW = 8;
`ifdef BUS_TURNAROUND_EN
  localparam int WR_GAP = 3;
`else
  localparam int WR_GAP = 2;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic req_ready, rsp_valid, rsp_we, mem_wr, mem_rd;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  always #5 clk = ~clk;
  mem_bus_master #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data)
  );
  logic [DW-1:0] mem [32];
  logic rd_q = 1'b0;
  logic [DW-1:0] rdata_q = '0;
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_data;
    rd_q    <= mem_rd;
    rdata_q <= mem[mem_addr];
  end
  assign mem_data = rd_q ? rdata_q : 'z;
  logic [DW-1:0] ref_mem [32];
  bit e_wr [8], e_rd [8], e_rdv [8], e_rv [8], e_rwe [8];
  logic [AW-1:0] e_addr [8];
  logic [DW-1:0] e_data [8];
  logic [DW-1:0] hold_rdata = '0;
  int w = 0, free_w = 0, vectors = 0, errors = 0;
  bit acc;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, w);
    end
  endtask
  task automatic clr(input int k);
    e_wr[k] = 0; e_rd[k] = 0; e_rdv[k] = 0; e_rv[k] = 0; e_rwe[k] = 0;
  endtask
  task automatic step(input bit r, input bit v, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int k;
    @(negedge clk);
    w++;
    k = w % 8;
    chk("req_ready", 32'(req_ready), 32'(w >= free_w));
    chk("mem_wr", 32'(mem_wr), 32'(e_wr[k]));
    chk("mem_rd", 32'(mem_rd), 32'(e_rd[k]));
    chk("wr_rd_excl", 32'(mem_wr && mem_rd), 32'(0));
    chk("bus_owner", 32'(dut.oe), 32'(e_wr[k]));
    if (e_wr[k] || e_rd[k]) chk("mem_addr", 32'(mem_addr), 32'(e_addr[k]));
    if (e_wr[k]) chk("wr_bus", 32'(mem_data), 32'(e_data[k]));
    if (e_rdv[k]) chk("rd_bus", 32'(mem_data), 32'(e_data[k]));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv[k]));
    if (e_rv[k]) chk("rsp_we", 32'(rsp_we), 32'(e_rwe[k]));
    if (e_rv[k] && !e_rwe[k]) hold_rdata = e_data[k];
    chk("rsp_rdata", 32'(rsp_rdata), 32'(hold_rdata));
    clr(k);
    rst = r;
    req_valid = v && !r;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    acc = 0;
    if (r) begin
      for (int i = 0; i < 8; i++) clr(i);
      free_w = w + 1;
      hold_rdata = '0;
    end else if (v && w >= free_w) begin
      acc = 1;
      if (we) begin
        e_wr[(w+1)%8] = 1; e_addr[(w+1)%8] = a; e_data[(w+1)%8] = d;
        e_rv[(w+2)%8] = 1; e_rwe[(w+2)%8] = 1;
        ref_mem[a] = d;
        free_w = w + WR_GAP;
      end else begin
        e_rd[(w+1)%8] = 1; e_addr[(w+1)%8] = a;
        e_rd[(w+2)%8] = 1; e_addr[(w+2)%8] = a; e_rdv[(w+2)%8] = 1; e_data[(w+2)%8] = ref_mem[a];
        e_rv[(w+3)%8] = 1; e_rwe[(w+3)%8] = 0; e_data[(w+3)%8] = ref_mem[a];
        free_w = w + 3;
      end
    end
  endtask
  task automatic req(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    do begin
      step(0, 1, we, a, d);
      n++;
    end while (!acc && n < 10);
    if (!acc) chk("accept_timeout", 32'(0), 32'(1));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'($urandom), AW'($urandom), DW'($urandom));
  endtask
  initial begin
    repeat (2) @(posedge clk);
    step(1, 0, 0, '0, '0);
    step(1, 0, 0, '0, '0);
    idle(2);
    chk("reset_addr", 32'(mem_addr), 32'(0));
    for (int i = 0; i < 32; i++) req(1, AW'(i), (i == 0) ? 8'h11 : (i == 1) ? 8'h22 : DW'($urandom));
    idle(3);
    req(1, 5'h03, 8'hA5);
    idle(3);
    chk("mem3", 32'(mem[3]), 32'(8'hA5));
    req(1, 5'h1F, 8'h3C);
    req(0, 5'h1F, 8'h00);
    idle(4);
    chk("rd_1f", 32'(rsp_rdata), 32'(8'h3C));
    req(0, 5'h00, 8'h00);
    req(0, 5'h01, 8'h00);
    idle(4);
    chk("rd_01", 32'(rsp_rdata), 32'(8'h22));
    req(1, 5'h0A, 8'h5A);
    step(0, 1, 1, 5'h0B, 8'hFF);
    step(0, 0, 0, 5'h0C, 8'h00);
    idle(3);
    chk("mem0a", 32'(mem[10]), 32'(8'h5A));
    chk("mem0b", 32'(mem[11]), 32'(ref_mem[11]));
    req(0, 5'h04, 8'h00);
    step(0, 0, 0, '0, '0);
    step(1, 0, 0, '0, '0);
    step(1, 0, 0, '0, '0);
    idle(4);
    chk("abort_rdata", 32'(rsp_rdata), 32'(0));
    chk("abort_addr", 32'(mem_addr), 32'(0));
    for (int i = 0; i < 3000; i++)
      step($urandom_range(99) == 0, $urandom_range(2) != 0, 1'($urandom), AW'($urandom), DW'($urandom));
    idle(5);
    for (int i = 0; i < 32; i++) chk("final_mem", 32'(mem[i]), 32'(ref_mem[i]));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
